// File: rtl/coproc_dispatch.sv
// rtl/coproc_dispatch.sv - single-transaction dispatcher between the grant arbiter and a shared coprocessor
//
// Purpose:
//   Takes the arbiter's grant, captures the lowest granted client's command
//   (opcode + two operands), issues it to the coprocessor with a valid/ready
//   handshake, waits for done (guarded by a watchdog) and returns the result
//   to the originating client as a one-hot pulse. One command in flight.
//
// Ports:
//   in_clk            clock, posedge
//   in_reset          asynchronous active-low reset
//   in_grant          one-hot grant from arbiter (bit i = client i)
//   in_op/opa/opb     packed per-client opcode / operand A / operand B
//   out_ack           1-cycle one-hot pulse: command of that client captured
//   out_valid         command valid towards the coprocessor
//   out_op/out_a/out_b registered command
//   out_src           index of the client being served
//   in_ready          coprocessor accepts command when out_valid & in_ready
//   in_done/in_result coprocessor completion and result (sampled in WAIT only)
//   out_result        registered result, held until the next retire
//   out_result_valid  1-cycle one-hot pulse to the owner of out_result
//   out_err           1-cycle pulse: multi-bit grant or watchdog abort

module coproc_dispatch #(
   parameter int width   = 4,
   parameter int data_w  = 32,
   parameter int opc_w   = 4,
   parameter int timeout = 8,
   localparam int SRC_W  = (width > 1) ? $clog2(width) : 1
) (
   input  logic                      in_clk,
   input  logic                      in_reset,
   input  logic [width-1:0]          in_grant,
   input  logic [width*opc_w-1:0]    in_op,
   input  logic [width*data_w-1:0]   in_opa,
   input  logic [width*data_w-1:0]   in_opb,
   output logic [width-1:0]          out_ack,
   output logic                      out_valid,
   output logic [opc_w-1:0]          out_op,
   output logic [data_w-1:0]         out_a,
   output logic [data_w-1:0]         out_b,
   output logic [SRC_W-1:0]          out_src,
   input  logic                      in_ready,
   input  logic                      in_done,
   input  logic [data_w-1:0]         in_result,
   output logic [data_w-1:0]         out_result,
   output logic [width-1:0]          out_result_valid,
   output logic                      out_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_RETIRE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [width-1:0]     r_ack;
   logic [opc_w-1:0]     r_op;
   logic [data_w-1:0]    r_a;
   logic [data_w-1:0]    r_b;
   logic [SRC_W-1:0]     r_src;
   logic [data_w-1:0]    r_result;
   logic                 r_err;
   logic [timeout-1:0]   r_wd;

   logic [SRC_W-1:0]     w_sel;
   logic [width-1:0]     w_lowbit;
   logic                 w_multi;
   logic [opc_w-1:0]     w_op;
   logic [data_w-1:0]    w_a;
   logic [data_w-1:0]    w_b;
   logic [timeout-1:0]   w_wd_next;
   logic                 w_wd_expire;

   // Two's-complement trick isolates the lowest set grant bit; any bit left
   // over after clearing it means the grant was not one-hot.
   assign w_lowbit = in_grant & (~in_grant + width'(1));
   assign w_multi  = |(in_grant & ~w_lowbit);

   always_comb begin
      w_sel = '0;
      for (int i = width - 1; i >= 0; i--) begin
         if (in_grant[i]) begin
            w_sel = SRC_W'(i);
         end
      end
   end

   always_comb begin
      w_op = in_op [int'(w_sel)*opc_w  +: opc_w];
      w_a  = in_opa[int'(w_sel)*data_w +: data_w];
      w_b  = in_opb[int'(w_sel)*data_w +: data_w];
   end

   // Abort on the WAIT edge at which the watchdog would reach all-ones,
   // i.e. after 2**timeout-1 cycles in WAIT without done.
   assign w_wd_next   = r_wd + timeout'(1);
   assign w_wd_expire = &w_wd_next;

   // State register
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (|in_grant)                  w_state_next = S_ISSUE;
         S_ISSUE:  if (in_ready)                   w_state_next = S_WAIT;
         S_WAIT:   if (in_done || w_wd_expire)     w_state_next = S_RETIRE;
         S_RETIRE:                                 w_state_next = S_IDLE;
         default:                                  w_state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      out_valid        = (r_state == S_ISSUE);
      out_result_valid = '0;
      if (r_state == S_RETIRE) begin
         out_result_valid = width'(1) << r_src;
      end
   end

   // Command capture, watchdog and result registers
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_ack    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_src    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_wd     <= '0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|in_grant) begin
                  r_op  <= w_op;
                  r_a   <= w_a;
                  r_b   <= w_b;
                  r_src <= w_sel;
                  r_ack <= w_lowbit;
                  r_err <= w_multi;
               end
            end
            S_ISSUE: begin
               if (in_ready) begin
                  r_wd <= '0;
               end
            end
            S_WAIT: begin
               if (in_done) begin
                  r_result <= in_result;
               end else if (w_wd_expire) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
               end else begin
                  r_wd <= w_wd_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_ack    = r_ack;
   assign out_op     = r_op;
   assign out_a      = r_a;
   assign out_b      = r_b;
   assign out_src    = r_src;
   assign out_result = r_result;
   assign out_err    = r_err;

endmodule

// File: tb/tb_coproc_dispatch.sv
// tb/tb_coproc_dispatch.sv - randomized self-checking bench for coproc_dispatch

module tb_coproc_dispatch;

   localparam int W   = 4;
   localparam int DW  = 32;
   localparam int OW  = 4;
   localparam int TMO = 3;
   localparam int SW  = 2;

   logic              in_clk = 1'b0;
   logic              in_reset;
   logic [W-1:0]      in_grant;
   logic [W*OW-1:0]   in_op;
   logic [W*DW-1:0]   in_opa;
   logic [W*DW-1:0]   in_opb;
   logic [W-1:0]      out_ack;
   logic              out_valid;
   logic [OW-1:0]     out_op;
   logic [DW-1:0]     out_a;
   logic [DW-1:0]     out_b;
   logic [SW-1:0]     out_src;
   logic              in_ready;
   logic              in_done;
   logic [DW-1:0]     in_result;
   logic [DW-1:0]     out_result;
   logic [W-1:0]      out_result_valid;
   logic              out_err;

   int                n_checks = 0;
   int                n_errors = 0;
   logic [DW-1:0]     exp_result = '0;

   always #5 in_clk = ~in_clk;

   coproc_dispatch #(.width(W), .data_w(DW), .opc_w(OW), .timeout(TMO)) dut (
      .in_clk           (in_clk),
      .in_reset         (in_reset),
      .in_grant         (in_grant),
      .in_op            (in_op),
      .in_opa           (in_opa),
      .in_opb           (in_opb),
      .out_ack          (out_ack),
      .out_valid        (out_valid),
      .out_op           (out_op),
      .out_a            (out_a),
      .out_b            (out_b),
      .out_src          (out_src),
      .in_ready         (in_ready),
      .in_done          (in_done),
      .in_result        (in_result),
      .out_result       (out_result),
      .out_result_valid (out_result_valid),
      .out_err          (out_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic rand_clients();
      for (int i = 0; i < W; i++) begin
         in_op[i*OW +: OW]  = OW'($urandom);
         in_opa[i*DW +: DW] = $urandom;
         in_opb[i*DW +: DW] = $urandom;
      end
   endtask

   function automatic int lowest(input logic [W-1:0] g);
      for (int i = 0; i < W; i++) begin
         if (g[i]) return i;
      end
      return 0;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   out_ack, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_op"},    out_op, 0);
      check({tag, "_a"},     out_a, 0);
      check({tag, "_b"},     out_b, 0);
      check({tag, "_src"},   out_src, 0);
      check({tag, "_res"},   out_result, 0);
      check({tag, "_rv"},    out_result_valid, 0);
      check({tag, "_err"},   out_err, 0);
   endtask

   // One full transaction starting in IDLE with grant g. rd = cycles of
   // ready low before accept, dd = WAIT cycles before done, hang = done never
   // comes, wander = grant moves randomly after capture, g_next = grant shown
   // during RETIRE (must not be captured there).
   task automatic run_txn(input logic [W-1:0] g, input int rd, input int dd, input bit hang,
                          input bit wander, input bit directed, input logic [W-1:0] g_next);
      int            s;
      logic [W-1:0]  eoh;
      logic [OW-1:0] eop;
      logic [DW-1:0] ea, eb, res;
      in_grant = g;
      in_ready = 1'b0;
      in_done  = 1'b0;
      rand_clients();
      s = lowest(g);
      if (directed) begin
         in_op[s*OW +: OW]  = OW'(3);
         in_opa[s*DW +: DW] = 32'd5;
         in_opb[s*DW +: DW] = 32'd7;
      end
      eoh    = '0;
      eoh[s] = 1'b1;
      eop    = in_op[s*OW +: OW];
      ea     = in_opa[s*DW +: DW];
      eb     = in_opb[s*DW +: DW];
      step();
      check("cap_ack",   out_ack, eoh);
      check("cap_valid", out_valid, 1);
      check("cap_op",    out_op, eop);
      check("cap_a",     out_a, ea);
      check("cap_b",     out_b, eb);
      check("cap_src",   out_src, s);
      check("cap_err",   out_err, ($countones(g) > 1));
      check("cap_rv",    out_result_valid, 0);
      check("cap_hold",  out_result, exp_result);
      rand_clients();
      in_grant = wander ? W'($urandom) : g;
      for (int i = 0; i < rd; i++) begin
         in_done = 1'($urandom);
         step();
         check("iss_valid", out_valid, 1);
         check("iss_ack",   out_ack, 0);
         check("iss_op",    out_op, eop);
         check("iss_a",     out_a, ea);
         check("iss_b",     out_b, eb);
         check("iss_src",   out_src, s);
         check("iss_err",   out_err, 0);
         check("iss_rv",    out_result_valid, 0);
         if (wander) in_grant = W'($urandom);
         rand_clients();
      end
      in_ready = 1'b1;
      in_done  = 1'($urandom);
      step();
      check("acc_valid", out_valid, 0);
      check("acc_rv",    out_result_valid, 0);
      check("acc_err",   out_err, 0);
      in_ready = 1'b0;
      if (!hang) begin
         for (int i = 0; i < dd; i++) begin
            in_done = 1'b0;
            if (wander) in_grant = W'($urandom);
            step();
            check("wait_rv",   out_result_valid, 0);
            check("wait_err",  out_err, 0);
            check("wait_hold", out_result, exp_result);
         end
         res       = directed ? 32'd12 : $urandom;
         in_result = res;
         in_done   = 1'b1;
         step();
         check("ret_rv",  out_result_valid, eoh);
         check("ret_res", out_result, res);
         check("ret_err", out_err, 0);
         exp_result = res;
      end else begin
         for (int i = 0; i < (1 << TMO) - 2; i++) begin
            in_done   = 1'b0;
            in_result = $urandom;
            step();
            check("wd_rv",  out_result_valid, 0);
            check("wd_err", out_err, 0);
         end
         step();
         check("wd_abort_err", out_err, 1);
         check("wd_abort_res", out_result, 0);
         check("wd_abort_rv",  out_result_valid, eoh);
         exp_result = '0;
      end
      in_done  = 1'b0;
      in_grant = g_next;
      step();
      check("post_ack",   out_ack, 0);
      check("post_valid", out_valid, 0);
      check("post_rv",    out_result_valid, 0);
      check("post_err",   out_err, 0);
      check("post_hold",  out_result, exp_result);
   endtask

   initial begin
      logic [W-1:0] g, gn;
      in_reset  = 1'b0;
      in_grant  = '0;
      in_op     = '0;
      in_opa    = '0;
      in_opb    = '0;
      in_ready  = 1'b0;
      in_done   = 1'b0;
      in_result = '0;
      step();
      check_all_zero("rst");
      #4 in_reset = 1'b1;

      // idle with no grant
      for (int i = 0; i < 3; i++) begin
         in_ready = 1'($urandom);
         in_done  = 1'($urandom);
         step();
         check("idle_valid", out_valid, 0);
         check("idle_ack",   out_ack, 0);
         check("idle_rv",    out_result_valid, 0);
      end

      // directed scenarios
      run_txn(4'b0100, 0, 1, 1'b0, 1'b0, 1'b1, 4'b0110);
      run_txn(4'b0110, 5, 0, 1'b0, 1'b0, 1'b0, 4'b0100);
      run_txn(4'b0100, 2, 3, 1'b0, 1'b1, 1'b0, 4'b1000);
      run_txn(4'b1000, 1, 0, 1'b1, 1'b0, 1'b0, 4'b0001);
      run_txn(4'b0001, 0, 6, 1'b0, 1'b0, 1'b0, 4'b0000);

      // reset during WAIT
      in_grant = 4'b0010;
      rand_clients();
      step();
      in_grant = '0;
      in_ready = 1'b1;
      step();
      in_ready = 1'b0;
      step();
      #2 in_reset = 1'b0;
      #1 check_all_zero("midrst");
      exp_result = '0;
      #2 in_reset = 1'b1;
      in_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("midrst_rv",    out_result_valid, 0);
         check("midrst_valid", out_valid, 0);
         check("midrst_err",   out_err, 0);
      end
      in_done = 1'b0;

      // randomized transactions
      g = W'($urandom_range(1, (1 << W) - 1));
      for (int t = 0; t < 30; t++) begin
         gn = W'($urandom_range(0, (1 << W) - 1));
         if (gn == 0) gn = 4'b0001;
         run_txn(g, $urandom_range(0, 5), $urandom_range(0, (1 << TMO) - 2),
                 ($urandom_range(0, 4) == 0), 1'($urandom), 1'b0, gn);
         g = gn;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
